memory_access_stage: RTL

Pipeline stage between Execute and WriteBack. Registers the Execute result, performs at most one data-memory load or store per instruction over a valid/ready request plus response-valid bus, and aligns and extends load data. Drives the WriteBack stage's next-stage bundle (pc, rd write control) and holds the pipeline through `stall` while a memory transaction is outstanding.

---
 rtl/memory_access_stage_pkg.sv | 71 +++++++
 rtl/memory_access_stage_mem_lane_align.sv | 65 ++++++
 rtl/memory_access_stage.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/memory_access_stage_pkg.sv
// ---------------------------------------------------------------------------
// memory_access_stage_pkg
// Shared pipeline definitions for the memory access stage:
//   MemSize               - access size encoding carried from Execute
//   MemAccessState        - memory transaction FSM states
//   MemAccessStagePipeReg - Execute -> Memory pipe register contents
//   PIPE_REG_RESET        - reset value of the pipe register
// Helper functions compute the force-aligned address and the misalignment
// condition for a given access size.
// ---------------------------------------------------------------------------
package memory_access_stage_pkg;

  localparam int STAGE_XLEN = 32;

  typedef enum logic [1:0] {
    MEM_SIZE_BYTE = 2'b00,
    MEM_SIZE_HALF = 2'b01,
    MEM_SIZE_WORD = 2'b10,
    MEM_SIZE_RSVD = 2'b11   // illegal encoding, handled as a word access
  } MemSize;

  typedef enum logic [1:0] {
    MA_IDLE      = 2'b00,
    MA_WAIT_RESP = 2'b01,
    MA_DRAIN     = 2'b10
  } MemAccessState;

  typedef struct packed {
    logic                  valid;
    logic [STAGE_XLEN-1:0] pc;
    logic [STAGE_XLEN-1:0] addr;
    logic [STAGE_XLEN-1:0] store_data;
    logic                  mem_read;
    logic                  mem_write;
    MemSize                mem_size;
    logic                  mem_unsigned;
    logic                  rd_write;
    logic [4:0]            rd_addr;
  } MemAccessStagePipeReg;

  localparam MemAccessStagePipeReg PIPE_REG_RESET = '0;

  // Clear the low address bits that a natural alignment of this size forbids.
  function automatic logic [STAGE_XLEN-1:0] force_align(
    input logic [STAGE_XLEN-1:0] addr,
    input MemSize                size
  );
    logic [STAGE_XLEN-1:0] aligned;
    aligned = addr;
    case (size)
      MEM_SIZE_BYTE: aligned = addr;
      MEM_SIZE_HALF: aligned[0] = 1'b0;
      default:       aligned[1:0] = 2'b00;
    endcase
    return aligned;
  endfunction

  function automatic logic is_misaligned(
    input logic [1:0] addr_low,
    input MemSize     size
  );
    logic mis;
    case (size)
      MEM_SIZE_BYTE: mis = 1'b0;
      MEM_SIZE_HALF: mis = addr_low[0];
      default:       mis = (addr_low != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/memory_access_stage_mem_lane_align.sv
// ---------------------------------------------------------------------------
// mem_lane_align
// Purely combinational byte-lane steering for the memory access stage.
//   addr_low      in  address bits [1:0] (already force-aligned for size)
//   size          in  access size
//   load_unsigned in  zero-extend (1) or sign-extend (0) the load value
//   store_data    in  right-aligned store operand
//   load_word     in  raw 32-bit word returned by memory
//   store_wdata   out store operand replicated into every lane it may occupy
//   store_wstrb   out byte enables for the store
//   load_value    out extracted and extended load value
// ---------------------------------------------------------------------------
module mem_lane_align
  import memory_access_stage_pkg::*;
(
  input  logic [1:0]  addr_low,
  input  MemSize      size,
  input  logic        load_unsigned,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [31:0] store_wdata,
  output logic [3:0]  store_wstrb,
  output logic [31:0] load_value
);

  logic       is_byte;
  logic       is_half;
  logic [7:0] word_bytes [4];
  logic [7:0] load_byte;
  logic [15:0] load_half;

  assign is_byte = (size == MEM_SIZE_BYTE);
  assign is_half = (size == MEM_SIZE_HALF);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);

      // Replication means every lane already carries the right byte; the
      // strobe alone selects which lanes memory actually writes.
      assign store_wstrb[gi] = is_byte ? (addr_low == LANE) :
                               is_half ? (addr_low[1] == LANE[1]) :
                                         1'b1;
      assign store_wdata[gi*8 +: 8] = is_byte ? store_data[7:0] :
                                      is_half ? store_data[(gi%2)*8 +: 8] :
                                                store_data[gi*8 +: 8];
      assign word_bytes[gi] = load_word[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    load_byte = word_bytes[addr_low];
    load_half = addr_low[1] ? load_word[31:16] : load_word[15:0];
    case (size)
      MEM_SIZE_BYTE:
        load_value = {{24{~load_unsigned & load_byte[7]}}, load_byte};
      MEM_SIZE_HALF:
        load_value = {{16{~load_unsigned & load_half[15]}}, load_half};
      default:
        load_value = load_word;
    endcase
  end

endmodule

// File: rtl/memory_access_stage.sv
// ---------------------------------------------------------------------------
// memory_access_stage
// Pipeline stage between Execute and WriteBack. Registers the Execute
// result, performs at most one load or store per instruction on a
// valid/ready request bus with a separate response-valid, and aligns and
// extends load data for WriteBack.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   flush               kill the instruction held in this stage
//   ex_*                Execute outputs captured when stall = 0
//   stall               Execute must hold; this stage does not capture
//   dmem_req_*          request channel (word-aligned address, strobes)
//   dmem_resp_*         load response channel
//   wb_*                combinational bundle registered by WriteBack
//   misaligned_exc      one-cycle misaligned access pulse
//
// Build option: define MISALIGNED_EXC_EN to trap misaligned half/word
// accesses instead of force-aligning them.
// ---------------------------------------------------------------------------
module memory_access_stage
  import memory_access_stage_pkg::*;
#(
  parameter int XLEN = 32   // only 32 is supported
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_addr,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic            ex_mem_read,
  input  logic            ex_mem_write,
  input  logic [1:0]      ex_mem_size,
  input  logic            ex_mem_unsigned,
  input  logic            ex_rd_write,
  input  logic [4:0]      ex_rd_addr,
  output logic            stall,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic [XLEN-1:0] dmem_req_addr,
  output logic            dmem_req_we,
  output logic [3:0]      dmem_req_wstrb,
  output logic [XLEN-1:0] dmem_req_wdata,
  input  logic            dmem_resp_valid,
  input  logic [XLEN-1:0] dmem_resp_rdata,
  output logic            wb_valid,
  output logic [XLEN-1:0] wb_pc,
  output logic            wb_rd_write,
  output logic [4:0]      wb_rd_addr,
  output logic [XLEN-1:0] wb_rd_value,
  output logic            misaligned_exc
);

  MemAccessState        state_reg;
  MemAccessState        state_next;
  MemAccessStagePipeReg pipe_reg;
  MemAccessStagePipeReg pipe_next;

  logic        is_mem_op;
  logic        misaligned;
  logic        use_load;
  logic [31:0] aligned_addr;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_wstrb;
  logic [31:0] load_value;

  // -------------------------------------------------------------------------
  // Pipe register input
  // -------------------------------------------------------------------------
  always_comb begin
    pipe_next              = PIPE_REG_RESET;
    pipe_next.valid        = ex_valid & ~flush;
    pipe_next.pc           = ex_pc;
    pipe_next.addr         = ex_addr;
    pipe_next.store_data   = ex_store_data;
    pipe_next.mem_read     = ex_mem_read;
    pipe_next.mem_write    = ex_mem_write;
    pipe_next.mem_size     = MemSize'(ex_mem_size);
    pipe_next.mem_unsigned = ex_mem_unsigned;
    pipe_next.rd_write     = ex_rd_write;
    pipe_next.rd_addr      = ex_rd_addr;
  end

  // -------------------------------------------------------------------------
  // Address handling
  // -------------------------------------------------------------------------
  assign is_mem_op    = pipe_reg.mem_read | pipe_reg.mem_write;
  assign aligned_addr = force_align(pipe_reg.addr, pipe_reg.mem_size);

`ifdef MISALIGNED_EXC_EN
  assign misaligned = is_misaligned(pipe_reg.addr[1:0], pipe_reg.mem_size);
`else
  // Misaligned accesses are silently force-aligned and proceed.
  assign misaligned = 1'b0;
`endif

  mem_lane_align u_lane_align (
    .addr_low      (aligned_addr[1:0]),
    .size          (pipe_reg.mem_size),
    .load_unsigned (pipe_reg.mem_unsigned),
    .store_data    (pipe_reg.store_data),
    .load_word     (dmem_resp_rdata),
    .store_wdata   (lane_wdata),
    .store_wstrb   (lane_wstrb),
    .load_value    (load_value)
  );

  // -------------------------------------------------------------------------
  // Transaction control and output bundle
  // -------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    stall          = 1'b0;
    dmem_req_valid = 1'b0;
    wb_valid       = 1'b0;
    wb_rd_write    = 1'b0;
    use_load       = 1'b0;
    misaligned_exc = 1'b0;

    case (state_reg)
      MA_IDLE: begin
        // A flush here drops the held instruction and withdraws any
        // request that has not yet been accepted.
        if (pipe_reg.valid && !flush) begin
          if (!is_mem_op) begin
            wb_valid    = 1'b1;
            wb_rd_write = pipe_reg.rd_write;
          end else if (misaligned) begin
            misaligned_exc = 1'b1;
            wb_valid       = 1'b1;
          end else begin
            dmem_req_valid = 1'b1;
            if (dmem_req_ready) begin
              if (pipe_reg.mem_read) begin
                state_next = MA_WAIT_RESP;
                stall      = 1'b1;
              end else begin
                wb_valid = 1'b1;   // store retires on acceptance
              end
            end else begin
              stall = 1'b1;
            end
          end
        end
      end

      MA_WAIT_RESP: begin
        if (dmem_resp_valid) begin
          // A flush coinciding with the response ends the transaction
          // here; there is nothing left to drain.
          state_next = MA_IDLE;
          if (!flush) begin
            wb_valid    = 1'b1;
            wb_rd_write = pipe_reg.rd_write;
            use_load    = 1'b1;
          end
        end else begin
          stall = 1'b1;
          if (flush) begin
            state_next = MA_DRAIN;
          end
        end
      end

      MA_DRAIN: begin
        // Swallow the response of the killed load before accepting new work.
        if (dmem_resp_valid) begin
          state_next = MA_IDLE;
        end else begin
          stall = 1'b1;
        end
      end

      default: begin
        state_next = MA_IDLE;
      end
    endcase
  end

  assign dmem_req_addr  = {aligned_addr[31:2], 2'b00};
  assign dmem_req_we    = pipe_reg.mem_write;
  assign dmem_req_wstrb = pipe_reg.mem_write ? lane_wstrb : 4'b0000;
  assign dmem_req_wdata = pipe_reg.mem_write ? lane_wdata : 32'h0;

  assign wb_pc       = pipe_reg.pc;
  assign wb_rd_addr  = pipe_reg.rd_addr;
  assign wb_rd_value = use_load ? load_value : pipe_reg.addr;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= MA_IDLE;
      pipe_reg  <= PIPE_REG_RESET;
    end else begin
      state_reg <= state_next;
      if (!stall) begin
        pipe_reg <= pipe_next;
      end
    end
  end

endmodule
